// File: rtl/ai_mem_arbiter_if.sv
// ai_mem_arbiter_if
//   Bundles the three requester descriptor channels and the single burst
//   memory command/beat port shared by the round-robin memory arbiter.
//
//   master : arbiter side (drives mem command, done pulses, grant_id, busy)
//   slave  : environment side (requesters + memory; drives req/addr/len,
//            mem_ack, mem_beat)
//
//   rdN/wr2_req   requester holds high until its done pulse
//   rdN/wr2_addr  burst base address
//   rdN/wr2_len   burst length in beats
//   rdN/wr2_done  one-cycle completion pulse
//   mem_req/we/addr/len  burst command, held until mem_ack
//   mem_ack       memory accepts the command
//   mem_beat      one data beat transferred
//   grant_id      owner of current/last burst
//   busy          arbiter not idle
interface ai_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              rd0_req;
    logic [ADDR_W-1:0] rd0_addr;
    logic [LEN_W-1:0]  rd0_len;
    logic              rd0_done;

    logic              rd1_req;
    logic [ADDR_W-1:0] rd1_addr;
    logic [LEN_W-1:0]  rd1_len;
    logic              rd1_done;

    logic              wr2_req;
    logic [ADDR_W-1:0] wr2_addr;
    logic [LEN_W-1:0]  wr2_len;
    logic              wr2_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic              mem_ack;
    logic              mem_beat;

    logic [1:0]        grant_id;
    logic              busy;

    modport master (
        input  rd0_req, rd0_addr, rd0_len,
        input  rd1_req, rd1_addr, rd1_len,
        input  wr2_req, wr2_addr, wr2_len,
        output rd0_done, rd1_done, wr2_done,
        output mem_req, mem_we, mem_addr, mem_len,
        input  mem_ack, mem_beat,
        output grant_id, busy
    );

    modport slave (
        output rd0_req, rd0_addr, rd0_len,
        output rd1_req, rd1_addr, rd1_len,
        output wr2_req, wr2_addr, wr2_len,
        input  rd0_done, rd1_done, wr2_done,
        input  mem_req, mem_we, mem_addr, mem_len,
        output mem_ack, mem_beat,
        input  grant_id, busy
    );
endinterface

// File: rtl/ai_mem_arbiter.sv
// ai_mem_arbiter
//   Round-robin arbiter sharing one burst memory port between IFM reads
//   (port 0), weight reads (port 1) and OFM writes (port 2). In IDLE it picks
//   the first asserted request starting at rr_ptr, latches that descriptor,
//   issues it until mem_ack, counts mem_beat down to completion and then
//   pulses the owner's done for one cycle.
//
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : ai_mem_arbiter_if.master (requesters, memory port, grant_id, busy)
//
//   All outputs come straight from flops.
module ai_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ai_mem_arbiter_if.master     bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              we_q, we_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic [2:0]        done_q, done_d;

    logic [2:0]        req_vec;
    logic [1:0]        cand0, cand1, cand2;
    logic              pick_valid;
    logic [1:0]        pick_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign req_vec = {bus.wr2_req, bus.rd1_req, bus.rd0_req};

    // Search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
    assign cand0 = rr_ptr_q;
    assign cand1 = rr_next(cand0);
    assign cand2 = rr_next(cand1);

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = cand0;
        if (req_vec[cand0]) begin
            pick_valid = 1'b1;
            pick_id    = cand0;
        end else if (req_vec[cand1]) begin
            pick_valid = 1'b1;
            pick_id    = cand1;
        end else if (req_vec[cand2]) begin
            pick_valid = 1'b1;
            pick_id    = cand2;
        end
    end

    always_comb begin
        sel_addr = bus.rd0_addr;
        sel_len  = bus.rd0_len;
        case (pick_id)
            2'd1: begin
                sel_addr = bus.rd1_addr;
                sel_len  = bus.rd1_len;
            end
            2'd2: begin
                sel_addr = bus.wr2_addr;
                sel_len  = bus.wr2_len;
            end
            default: begin
                sel_addr = bus.rd0_addr;
                sel_len  = bus.rd0_len;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        len_d      = len_q;
        we_d       = we_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_id;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    we_d    = (pick_id == 2'd2);
                    // Zero-length bursts complete without touching memory.
                    state_d = (sel_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ack) begin
                    beat_cnt_d = len_q;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (bus.mem_beat) begin
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - LEN_ONE;
                    end
                    if (beat_cnt_q == LEN_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rr_ptr_d = rr_next(grant_q);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up
        // with the state they describe.
        mem_req_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
        done_d    = {grant_d == 2'd2, grant_d == 2'd1, grant_d == 2'd0}
                    & {3{state_d == DONE}};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            beat_cnt_q <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            we_q       <= we_d;
            beat_cnt_q <= beat_cnt_d;
            mem_req_q  <= mem_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_len  = len_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.rd0_done = done_q[0];
    assign bus.rd1_done = done_q[1];
    assign bus.wr2_done = done_q[2];

endmodule

// File: tb/tb_ai_mem_arbiter.sv
// tb_ai_mem_arbiter
//   Self-checking bench for ai_mem_arbiter. A transaction-level model
//   (pending command flag, beats remaining, pending done pulse, round-robin
//   pointer) predicts every output each cycle; directed sequences add
//   hand-computed literal expectations, followed by a randomized phase.
module tb_ai_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        t_req = '0;
    logic [ADDR_W-1:0] t_addr [3];
    logic [LEN_W-1:0]  t_len  [3];
    logic              t_ack  = 1'b0;
    logic              t_beat = 1'b0;
    logic [2:0]        dropped = '0;

    int n_chk  = 0;
    int n_fail = 0;

    ai_mem_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    ai_mem_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rd0_req  = t_req[0];
    assign bus.rd0_addr = t_addr[0];
    assign bus.rd0_len  = t_len[0];
    assign bus.rd1_req  = t_req[1];
    assign bus.rd1_addr = t_addr[1];
    assign bus.rd1_len  = t_len[1];
    assign bus.wr2_req  = t_req[2];
    assign bus.wr2_addr = t_addr[2];
    assign bus.wr2_len  = t_len[2];
    assign bus.mem_ack  = t_ack;
    assign bus.mem_beat = t_beat;

    logic [2:0] done_vec;
    assign done_vec = {bus.wr2_done, bus.rd1_done, bus.rd0_done};

    // ---------------- behavioural model ----------------
    bit                started = 1'b0;
    int                m_ptr   = 0;
    int                m_owner = 0;
    int                m_pulse = -1;   // requester whose done is showing, -1 none
    int                m_ended = -1;   // requester whose done cycle just ended
    int                m_left  = 0;    // beats still owed by memory
    bit                m_cmd   = 1'b0; // command presented, waiting for ack
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [LEN_W-1:0]  m_len   = '0;
    bit                m_we    = 1'b0;

    initial begin
        int  id;
        bit  found;
        forever begin
            @(posedge clk);
            started = 1'b1;
            m_ended = m_pulse;
            if (!rst) begin
                m_ptr = 0; m_owner = 0; m_pulse = -1; m_ended = -1; m_left = 0;
                m_cmd = 1'b0; m_addr = '0; m_len = '0; m_we = 1'b0;
            end else if (m_pulse >= 0) begin
                m_ptr   = (m_pulse + 1) % 3;
                m_pulse = -1;
            end else if (m_cmd) begin
                if (t_ack) begin
                    m_cmd  = 1'b0;
                    m_left = int'(m_len);
                end
            end else if (m_left > 0) begin
                if (t_beat) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_pulse = m_owner;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    id = (m_ptr + k) % 3;
                    if (!found && t_req[id]) begin
                        found   = 1'b1;
                        m_owner = id;
                        m_addr  = t_addr[id];
                        m_len   = t_len[id];
                        m_we    = (id == 2);
                        if (t_len[id] == '0) m_pulse = id;
                        else m_cmd = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the rising edge.
    initial begin
        logic [2:0] exp_done;
        forever begin
            @(negedge clk);
            if (started) begin
                exp_done = (m_pulse == 0) ? 3'b001 : (m_pulse == 1) ? 3'b010 :
                           (m_pulse == 2) ? 3'b100 : 3'b000;
                chk("mem_req",  64'(bus.mem_req),  64'(m_cmd));
                chk("mem_we",   64'(bus.mem_we),   64'(m_we));
                chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
                chk("mem_len",  64'(bus.mem_len),  64'(m_len));
                chk("grant_id", 64'(bus.grant_id), 64'(m_owner));
                chk("done",     64'(done_vec),     64'(exp_done));
                chk("busy",     64'(bus.busy),
                    64'(m_cmd || (m_left > 0) || (m_pulse >= 0)));
            end
        end
    end

    // One clock step; requesters drop req on the edge that ends their done cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            dropped[i] = (m_ended == i);
            if (dropped[i]) t_req[i] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         order [4];
        int         n_seen;
        logic [7:0] pat;

        for (int i = 0; i < 3; i++) begin
            t_addr[i] = '0;
            t_len[i]  = '0;
        end

        // ---- reset with random inputs ----
        for (int c = 0; c < 3; c++) begin
            t_req  = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                t_addr[i] = $urandom;
                t_len[i]  = 16'($urandom);
            end
            t_ack  = 1'($urandom);
            t_beat = 1'($urandom);
            tick();
            chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
            chk("rst_busy",    64'(bus.busy),    64'd0);
            chk("rst_done",    64'(done_vec),    64'd0);
            chk("rst_addr",    64'(bus.mem_addr), 64'd0);
        end

        // ---- release with rd1, addr 0x100 len 4 ----
        t_req = '0; t_ack = 1'b0; t_beat = 1'b0;
        t_addr[1] = 32'h0000_0100; t_len[1] = 16'd4; t_req[1] = 1'b1;
        rst = 1'b1;
        tick();
        chk("r1_mem_req", 64'(bus.mem_req), 64'd1);
        chk("r1_mem_we",  64'(bus.mem_we),  64'd0);
        chk("r1_addr",    64'(bus.mem_addr), 64'h100);
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0; t_beat = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("r1_done_early", 64'(bus.rd1_done), 64'd0);
            tick();
        end
        chk("r1_done", 64'(bus.rd1_done), 64'd1);
        t_beat = 1'b0;
        tick();

        // ---- round robin from rr_ptr = 0 ----
        rst = 1'b0; tick(); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t_len[i]  = 16'd2;
            t_addr[i] = 32'h1000 * (i + 1);
            order[i]  = 3;
        end
        order[3] = 3;
        t_req = '1; t_ack = 1'b1; t_beat = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 80 && n_seen < 4; c++) begin
            tick();
            for (int i = 0; i < 3; i++)
                if (!t_req[i] && !dropped[i]) t_req[i] = 1'b1;
            if (done_vec != 3'b000) begin
                chk("rr_onehot", 64'($countones(done_vec)), 64'd1);
                order[n_seen] = (done_vec == 3'b001) ? 0 : (done_vec == 3'b010) ? 1 : 2;
                n_seen++;
            end
        end
        chk("rr_count", 64'(n_seen), 64'd4);
        chk("rr_order0", 64'(order[0]), 64'd0);
        chk("rr_order1", 64'(order[1]), 64'd1);
        chk("rr_order2", 64'(order[2]), 64'd2);
        chk("rr_order3", 64'(order[3]), 64'd0);
        t_req = '0; t_ack = 1'b0; t_beat = 1'b0;
        tick();

        // ---- write path, ack delayed 5 cycles ----
        t_addr[2] = 32'hDEAD_BEE0; t_len[2] = 16'd8; t_req[2] = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("wr_mem_req", 64'(bus.mem_req),  64'd1);
            chk("wr_addr",    64'(bus.mem_addr), 64'hDEAD_BEE0);
            chk("wr_len",     64'(bus.mem_len),  64'd8);
            chk("wr_we",      64'(bus.mem_we),   64'd1);
            t_beat = 1'b1;
            t_ack  = (k == 5);
            tick();
        end
        t_ack = 1'b0;
        chk("wr_req_low", 64'(bus.mem_req), 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk("wr_done_early", 64'(bus.wr2_done), 64'd0);
            tick();
        end
        chk("wr_done", 64'(bus.wr2_done), 64'd1);
        t_beat = 1'b0;
        tick();

        // ---- zero length on rd0, then rr_ptr must be 1 ----
        t_addr[0] = 32'h0000_0A00; t_len[0] = 16'd0; t_req[0] = 1'b1;
        tick();
        chk("zl_done",    64'(bus.rd0_done), 64'd1);
        chk("zl_mem_req", 64'(bus.mem_req),  64'd0);
        tick();
        chk("zl_idle", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 3; i++) t_len[i] = 16'd1;
        t_req = '1;
        tick();
        chk("zl_rr_grant", 64'(bus.grant_id), 64'd1);
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0; t_beat = 1'b1;
        tick();
        chk("zl_rd1_done", 64'(bus.rd1_done), 64'd1);
        t_beat = 1'b0; t_req = '0;
        tick();

        // ---- gapped beats, descriptor change after grant ----
        t_addr[0] = 32'h0000_4000; t_len[0] = 16'd3; t_req[0] = 1'b1;
        tick();
        t_addr[0] = 32'h5555_0000;
        chk("gap_addr", 64'(bus.mem_addr), 64'h4000);
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        pat = 8'b1010_0010;
        for (int k = 0; k < 8; k++) begin
            chk("gap_done_early", 64'(bus.rd0_done), 64'd0);
            t_beat = pat[k];
            tick();
        end
        chk("gap_done",      64'(bus.rd0_done), 64'd1);
        chk("gap_addr_hold", 64'(bus.mem_addr), 64'h4000);
        t_beat = 1'b0;
        tick();

        // ---- reset mid-XFER ----
        t_addr[1] = 32'h0000_8000; t_len[1] = 16'd5; t_req[1] = 1'b1;
        tick();
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0; t_beat = 1'b1;
        tick();
        tick();
        t_beat = 1'b0; rst = 1'b0;
        tick();
        chk("rx_done",  64'(done_vec),     64'd0);
        chk("rx_busy",  64'(bus.busy),     64'd0);
        chk("rx_addr",  64'(bus.mem_addr), 64'd0);
        chk("rx_len",   64'(bus.mem_len),  64'd0);
        chk("rx_grant", 64'(bus.grant_id), 64'd0);
        rst = 1'b1;
        tick();
        chk("rx_reissue", 64'(bus.mem_req), 64'd1);
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0; t_beat = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("rx_done_early", 64'(bus.rd1_done), 64'd0);
            tick();
        end
        chk("rx_done_full", 64'(bus.rd1_done), 64'd1);
        t_beat = 1'b0;
        tick();

        // ---- long burst using upper length bits (257 beats) ----
        t_addr[2] = 32'h0001_0000; t_len[2] = 16'h0101; t_req[2] = 1'b1;
        tick();
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0; t_beat = 1'b1;
        for (int k = 0; k < 256; k++) tick();
        chk("long_done_early", 64'(bus.wr2_done), 64'd0);
        tick();
        chk("long_done", 64'(bus.wr2_done), 64'd1);
        t_beat = 1'b0;
        tick();

        // ---- randomized traffic ----
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!t_req[i] && !dropped[i] && ($urandom % 4 == 0)) begin
                    t_addr[i] = $urandom;
                    t_len[i]  = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 6));
                    t_req[i]  = 1'b1;
                end
            end
            t_ack  = ($urandom % 3 == 0);
            t_beat = 1'($urandom);
            rst    = ($urandom % 400 != 0);
            tick();
        end
        rst = 1'b1; t_req = '0; t_ack = 1'b0; t_beat = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ai_mem_arbiter.md
# ai_mem_arbiter

Round-robin arbiter that shares the accelerator's single burst memory port between three requesters: input-feature-map reads (port 0), weight reads (port 1) and output-feature-map writes (port 2). It sits between the layer control FSM / sequencer and the memory interface. It latches one burst descriptor (address, length, direction), drives it to memory until accepted, and counts data beats to completion. It then returns a one-cycle done pulse to the owning requester.

## Interface
Parameters:
- ADDR_W, 32, burst base address width
- LEN_W, 16, burst length width in beats

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- rd0_req  in  1  IFM read request; held until rd0_done
- rd0_addr  in  ADDR_W  IFM burst address
- rd0_len  in  LEN_W  IFM burst length (beats)
- rd0_done  out  1  one-cycle completion pulse
- rd1_req / rd1_addr / rd1_len / rd1_done  same widths and meanings, weight read
- wr2_req / wr2_addr / wr2_len / wr2_done  same widths and meanings, OFM write
- mem_req  out  1  burst command valid
- mem_we  out  1  1 = write burst (port 2), 0 = read
- mem_addr  out  ADDR_W  latched burst address
- mem_len  out  LEN_W  latched burst length
- mem_ack  in  1  memory accepts command this cycle (when mem_req=1)
- mem_beat  in  1  one data beat transferred this cycle
- grant_id  out  2  owner of current/last burst (0,1,2)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- **IDLE**
  - Sample the three req lines and pick the first asserted one, starting at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2, mod 3.
  - Latch that requester's addr/len into mem_addr/mem_len, set grant_id, and set mem_we = (id==2).
  - If latched len ≠ 0, go to ISSUE. If len = 0, go straight to DONE with no memory command.
  - No req asserted: stay in IDLE.
- **ISSUE**
  - mem_req=1, with addr/len/we held stable.
  - On mem_ack: load beat_cnt ← mem_len and go to XFER.
  - mem_beat is ignored in ISSUE.
- **XFER**
  - mem_req=0. Each mem_beat decrements beat_cnt.
  - On a beat with beat_cnt==1, go to DONE.
- **DONE**
  - The done pulse matching grant_id is high for this cycle only.
  - rr_ptr ← (grant_id+1) mod 3. Go to IDLE.
- Requesters contract:
  - Hold req, addr and len stable until done.
  - Deassert req on the edge ending the done cycle, so req is already low in the following IDLE cycle.
- A req that drops after grant has no effect; the burst runs to completion.
- Descriptor changes after the grant are ignored, since values were latched in IDLE.
- Width rules:
  - beat_cnt is LEN_W bits and never underflows; no beats are expected once it reaches 0.
  - A burst of length 2^LEN_W−1 is legal.
- Extra beats received in IDLE or DONE are ignored.

## Timing
- Reset (rst=0 at a rising edge) forces:
  - state=IDLE, rr_ptr=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_len=0
  - all done=0, grant_id=0, busy=0
- Reset mid-burst aborts immediately. No done pulse is issued.
- Request latency: req high in IDLE cycle T gives mem_req=1 in T+1 (earliest mem_ack in T+1).
- mem_ack in T+1 gives XFER from T+2. The N-th counted beat in cycle B gives done in B+1 and IDLE in B+2.
- Zero-length: req in T gives DONE in T+1 (done pulse) and IDLE in T+2.
- Minimum per-burst overhead is 3 non-beat cycles (IDLE, ISSUE, DONE). Back-to-back bursts to different owners therefore start every N+3 cycles at best.
- Simultaneous requests: resolved only in IDLE, by rr_ptr. There is no preemption.
- done outputs are mutually exclusive and registered.

## Test plan
- **Reset:** drive rst=0 with random inputs for 3 cycles -> all outputs 0, busy=0. Release with only rd1_req set (addr 0x100, len 4), 1-cycle ack, 4 beats -> mem_req 1 cycle after request, mem_we=0, rd1_done exactly 1 cycle after 4th beat.
- **Round robin:** hold all three reqs (len 2 each), immediate ack/beats -> grant order 0,1,2,0. Each requester re-asserts after its done. Only the owner's done pulses.
- **Write path:** wr2_req, addr 0xDEAD_BEE0, len 8, mem_ack delayed 5 cycles -> mem_req/addr/len/mem_we=1 held stable 6 cycles. Beats in ISSUE ignored. wr2_done after 8th XFER beat.
- **Zero length:** rd0_len=0 -> no mem_req, rd0_done 1 cycle after request, rr_ptr advances to 1.
- **Gapped beats / descriptor change:** len 3 with beats on cycles spaced 1,4,2 apart, and rd0_addr changed after grant -> mem_addr unchanged, done one cycle after the third beat.
- **Reset mid-XFER:** assert rst=0 after 2 of 5 beats -> no done pulse, outputs cleared, next burst counts from its full length.
